// File: rtl/approx_add_pkg.sv
// Shared definitions for the pipelined approximate adder.
//   kw()          : width of the run-time approximate-span field for a given APPROX_MAX
//   SUM_RST       : value held on sum while in reset
//   ERR_CNT_RST   : value held on err_count while in reset
package approx_add_pkg;

    localparam int unsigned SUM_RST     = 0;
    localparam int unsigned ERR_CNT_RST = 0;

    // Bits needed to express every k in 0..approx_max.
    function automatic int kw(input int approx_max);
        return $clog2(approx_max + 1);
    endfunction

endpackage

// File: rtl/approx_add_core.sv
// Combinational split adder: upper WIDTH-k bits added exactly, lower k bits
// OR-approximated, with a flag that reports any deviation from the exact sum.
//   a, b       : operands
//   carry_in   : carry into bit 0, honoured only for exact (k=0) addition
//   k          : requested approximate span, clamped to APPROX_MAX
//   sum        : WIDTH-bit result
//   carry_out  : carry out of the MSB
//   approx_err : {carry_out,sum} differs from a+b+carry_in
module approx_add_core
    import approx_add_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int APPROX_MAX = 16
) (
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    input  logic                           carry_in,
    input  logic [kw(APPROX_MAX)-1:0]      k,
    output logic [WIDTH-1:0]               sum,
    output logic                           carry_out,
    output logic                           approx_err
);

    localparam int KW = kw(APPROX_MAX);

    logic [KW-1:0]  k_c;
    logic [WIDTH:0] a_x, b_x;
    logic [WIDTH:0] exact;
    logic [WIDTH:0] lo_mask;
    logic [WIDTH:0] msb_sel;
    logic           c_lo;
    logic [WIDTH:0] hi_sum;
    logic [WIDTH:0] approx;
    logic [WIDTH:0] res;

    always_comb begin
        k_c     = (k > KW'(APPROX_MAX)) ? KW'(APPROX_MAX) : k;
        a_x     = {1'b0, a};
        b_x     = {1'b0, b};
        exact   = a_x + b_x + {{WIDTH{1'b0}}, carry_in};
        lo_mask = ((WIDTH+1)'(1) << k_c) - (WIDTH+1)'(1);
        // One-hot at bit k-1 (all zero for k=0): picks A[k-1]&B[k-1] as the
        // carry handed to the exact section.
        msb_sel = lo_mask ^ (lo_mask >> 1);
        c_lo    = |(a_x & b_x & msb_sel);
        hi_sum  = (a_x >> k_c) + (b_x >> k_c) + {{WIDTH{1'b0}}, c_lo};
        // hi_sum has at most WIDTH-k+1 significant bits, so the shift keeps
        // the upper carry in bit WIDTH.
        approx  = (hi_sum << k_c) | ((a_x | b_x) & lo_mask);
        res     = (k_c == '0) ? exact : approx;
    end

    assign sum        = res[WIDTH-1:0];
    assign carry_out  = res[WIDTH];
    assign approx_err = (res != exact);

endmodule

// File: rtl/pipelined_approx_adder.sv
// Two-stage valid/ready pipelined approximate adder with error profiling.
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid/in_ready      : input handshake; A, B, carry_in, approx_bits ride the beat
//   out_valid/out_ready    : output handshake; sum, carry_out, approx_err ride the beat
//   err_count              : saturating count of delivered results with approx_err=1
//   cnt_clr                : synchronous clear of err_count (wins over an increment)
// S1 holds the raw beat, S2 holds the computed result.
module pipelined_approx_adder
    import approx_add_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int APPROX_MAX = 16,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               A,
    input  logic [WIDTH-1:0]               B,
    input  logic                           carry_in,
    input  logic [kw(APPROX_MAX)-1:0]      approx_bits,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               sum,
    output logic                           carry_out,
    output logic                           approx_err,
    output logic [CNT_W-1:0]               err_count,
    input  logic                           cnt_clr
);

    localparam int KW = kw(APPROX_MAX);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_cin_q, s1_cin_d;
    logic [KW-1:0]    s1_k_q, s1_k_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_out_q, carry_out_d;
    logic             approx_err_q, approx_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0] core_sum;
    logic             core_co;
    logic             core_err;

    logic s2_load;
    logic s1_advance;
    logic in_fire;
    logic out_fire;

    approx_add_core #(
        .WIDTH      (WIDTH),
        .APPROX_MAX (APPROX_MAX)
    ) u_core (
        .a          (s1_a_q),
        .b          (s1_b_q),
        .carry_in   (s1_cin_q),
        .k          (s1_k_q),
        .sum        (core_sum),
        .carry_out  (core_co),
        .approx_err (core_err)
    );

    // in_ready looks through both stages to out_ready so a full pipe that is
    // draining still accepts a beat every cycle.
    assign out_fire   = s2_valid_q & out_ready;
    assign s2_load    = !s2_valid_q | out_ready;
    assign s1_advance = s1_valid_q & s2_load;
    assign in_ready   = !s1_valid_q | s1_advance;
    assign in_fire    = in_valid & in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_cin_d   = s1_cin_q;
        s1_k_d     = s1_k_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = A;
            s1_b_d     = B;
            s1_cin_d   = carry_in;
            s1_k_d     = approx_bits;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d   = s2_valid_q;
        sum_d        = sum_q;
        carry_out_d  = carry_out_q;
        approx_err_d = approx_err_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        // Result registers only change when a new beat lands, so they hold
        // steady through back-pressure.
        if (s1_advance) begin
            sum_d        = core_sum;
            carry_out_d  = core_co;
            approx_err_d = core_err;
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        if (cnt_clr) begin
            err_count_d = '0;
        end else if (out_fire && approx_err_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_cin_q     <= 1'b0;
            s1_k_q       <= '0;
            s2_valid_q   <= 1'b0;
            sum_q        <= WIDTH'(SUM_RST);
            carry_out_q  <= 1'b0;
            approx_err_q <= 1'b0;
            err_count_q  <= CNT_W'(ERR_CNT_RST);
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_cin_q     <= s1_cin_d;
            s1_k_q       <= s1_k_d;
            s2_valid_q   <= s2_valid_d;
            sum_q        <= sum_d;
            carry_out_q  <= carry_out_d;
            approx_err_q <= approx_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign sum        = sum_q;
    assign carry_out  = carry_out_q;
    assign approx_err = approx_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_pipelined_approx_adder.sv
module tb_pipelined_approx_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] A, B;
    logic        carry_in;
    logic [4:0]  approx_bits;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] sum;
    logic        carry_out;
    logic        approx_err;
    logic [2:0]  err_count;
    logic        cnt_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    pipelined_approx_adder #(
        .WIDTH      (24),
        .APPROX_MAX (16),
        .CNT_W      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .B           (B),
        .carry_in    (carry_in),
        .approx_bits (approx_bits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sum         (sum),
        .carry_out   (carry_out),
        .approx_err  (approx_err),
        .err_count   (err_count),
        .cnt_clr     (cnt_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated beat on an empty pipe with out_ready high.
    task automatic send_one(input string tag, input logic [23:0] a, input logic [23:0] b,
                            input logic cin, input logic [4:0] k,
                            input logic [23:0] e_sum, input logic e_co, input logic e_err);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        A = a; B = b; carry_in = cin; approx_bits = k; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        A = 24'h5A5A5A; B = 24'hA5A5A5; carry_in = ~cin; approx_bits = 5'd3;
        chk({tag, ".lat1"}, {31'd0, out_valid}, 32'd0);
        step();
        chk({tag, ".lat2"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".sum"},  {8'd0, sum}, {8'd0, e_sum});
        chk({tag, ".co"},   {31'd0, carry_out}, {31'd0, e_co});
        chk({tag, ".err"},  {31'd0, approx_err}, {31'd0, e_err});
        step();
        if (e_err && exp_cnt < 7) exp_cnt++;
        chk({tag, ".cnt"},  {29'd0, err_count}, exp_cnt);
        chk({tag, ".drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int sent, recv, stall_seen;
        logic [23:0] exp_s;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; carry_in = 1'b0;
        approx_bits = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        #1;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.sum",       {8'd0, sum}, 32'd0);
        chk("rst.co",        {31'd0, carry_out}, 32'd0);
        chk("rst.err",       {31'd0, approx_err}, 32'd0);
        chk("rst.cnt",       {29'd0, err_count}, 32'd0);
        chk("rst.in_ready",  {31'd0, in_ready}, 32'd1);
        step(); step();
        rst = 1'b0;
        step();

        // Directed arithmetic vectors
        send_one("t1_exact_ovf", 24'hFFFFFF, 24'h000001, 1'b0, 5'd0,  24'h000000, 1'b1, 1'b0);
        send_one("t2_k16",       24'h0100FF, 24'h020F01, 1'b1, 5'd16, 24'h030FFF, 1'b0, 1'b1);
        send_one("t3_k16_c",     24'h008000, 24'h008000, 1'b0, 5'd16, 24'h018000, 1'b0, 1'b1);
        send_one("t3_clamp31",   24'h008000, 24'h008000, 1'b0, 5'd31, 24'h018000, 1'b0, 1'b1);
        send_one("k4_noerr",     24'h000003, 24'h00000C, 1'b0, 5'd4,  24'h00000F, 1'b0, 1'b0);
        send_one("k4_cin_ign",   24'h000003, 24'h00000C, 1'b1, 5'd4,  24'h00000F, 1'b0, 1'b1);
        send_one("k8_ovf",       24'hFFFF80, 24'h000080, 1'b0, 5'd8,  24'h000080, 1'b1, 1'b1);
        send_one("k0_cin",       24'h123456, 24'h111111, 1'b1, 5'd0,  24'h234568, 1'b0, 1'b0);

        // Stream 10 beats, back-pressure in cycles 3..6
        sent = 0; recv = 0; stall_seen = 0;
        for (int c = 0; c < 60 && recv < 10; c++) begin
            out_ready   = !(c >= 3 && c <= 6);
            in_valid    = (sent < 10);
            A           = 24'(sent * 24'h111 + 1);
            B           = 24'(24'h100000 + sent);
            carry_in    = 1'b0;
            approx_bits = 5'd0;
            #1;
            if (out_valid && out_ready) begin
                exp_s = 24'(recv * 24'h111 + 1 + 24'h100000 + recv);
                chk($sformatf("stream.sum%0d", recv), {8'd0, sum}, {8'd0, exp_s});
                recv++;
            end
            if (in_valid && !in_ready) stall_seen = 1;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream.sent",  sent, 32'd10);
        chk("stream.recv",  recv, 32'd10);
        chk("stream.stall", stall_seen, 32'd1);
        step();
        chk("stream.nodup", {31'd0, out_valid}, 32'd0);
        chk("stream.cnt",   {29'd0, err_count}, exp_cnt);

        // Counter: clear, saturate, clear-over-increment
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0; exp_cnt = 0;
        chk("cnt.clr", {29'd0, err_count}, 32'd0);
        A = 24'h008000; B = 24'h008000; approx_bits = 5'd16; carry_in = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("cnt.sat", {29'd0, err_count}, 32'd7);
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("cnt.clr2", {29'd0, err_count}, 32'd0);
        in_valid = 1'b1; step(); in_valid = 1'b0; step(); step();
        chk("cnt.one", {29'd0, err_count}, 32'd1);
        in_valid = 1'b1; step(); in_valid = 1'b0; step();
        chk("cnt.pend_valid", {31'd0, out_valid}, 32'd1);
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("cnt.clr_prio", {29'd0, err_count}, 32'd0);

        // Reset with two beats in flight
        A = 24'h000010; B = 24'h000020; approx_bits = 5'd0;
        in_valid = 1'b1; step(); step(); in_valid = 1'b0;
        chk("rst6.full", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst6.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst6.sum",       {8'd0, sum}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst6.quiet%0d", i), {31'd0, out_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
